// File: rtl/red_seq_unit.sv
// Multi-cycle nibble reduction: sums the eight signed 4-bit lanes of A and B,
// one lane pair per clock, and reports the sign-extended total with a zero flag.
module red_seq_unit #(
   parameter int DATA_W  = 16,
   parameter int NIB_W   = 4,
   parameter int NUM_NIB = 4,
   parameter int ACC_W   = NIB_W + $clog2(2 * NUM_NIB)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   localparam int CNT_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [DATA_W-1:0] r_result;
   logic [CNT_W-1:0]  r_cnt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [NIB_W-1:0]  w_nib_a;
   logic [NIB_W-1:0]  w_nib_b;
   logic              r_busy;
   logic              r_done;
   logic              r_zero;
   logic              w_accept;
   logic              w_last;

   // start is only honoured when no reduction is in flight.
   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last   = (r_cnt == LAST_CNT);

   assign w_nib_a   = r_op_a[r_cnt*NIB_W +: NIB_W];
   assign w_nib_b   = r_op_b[r_cnt*NIB_W +: NIB_W];
   assign w_acc_nxt = r_acc
                    + {{(ACC_W-NIB_W){w_nib_a[NIB_W-1]}}, w_nib_a}
                    + {{(ACC_W-NIB_W){w_nib_b[NIB_W-1]}}, w_nib_b};

   // NOTE: assign every always_comb output a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_ACCUM;
         S_ACCUM: if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_ACCUM : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_ACCUM);
         r_done  <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_op_a <= A;
            r_op_b <= B;
            r_acc  <= '0;
            r_cnt  <= '0;
         end else if (r_state == S_ACCUM) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_result <= {{(DATA_W-ACC_W){w_acc_nxt[ACC_W-1]}}, w_acc_nxt};
               r_zero   <= (w_acc_nxt == '0);
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign zero   = r_zero;

endmodule

// File: tb/tb_red_seq_unit.sv
// Self-checking bench for red_seq_unit: directed corner cases plus random
// operands compared against an arithmetic nibble-sum model.
module tb_red_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        zero;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_result;
   logic        exp_zero;

   always #5 clk = ~clk;

   red_seq_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   // Reference: add the eight signed 4-bit lanes as plain integers.
   function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
      int total;
      total = 0;
      for (int i = 0; i < 4; i++) begin
         int na;
         int nb;
         na = int'((a >> (4 * i)) & 16'h000F);
         nb = int'((b >> (4 * i)) & 16'h000F);
         if (na > 7) na = na - 16;
         if (nb > 7) nb = nb - 16;
         total = total + na + nb;
      end
      return 16'(total);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete operation with a single-cycle start; also scrambles A/B and
   // pulses start during ACCUM to show both are ignored.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
      logic [15:0] exp_new;
      exp_new = ref_sum(a, b);
      A = a;
      B = b;
      start = 1'b1;
      step();
      A = 16'($urandom);
      B = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
         check({tag, " busy"}, {15'b0, busy}, 16'd1);
         check({tag, " done early"}, {15'b0, done}, 16'd0);
         check({tag, " hold"}, result, exp_result);
         start = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
      end
      exp_result = exp_new;
      exp_zero   = (exp_new == 16'h0000);
      check({tag, " done"}, {15'b0, done}, 16'd1);
      check({tag, " busy at done"}, {15'b0, busy}, 16'd0);
      check({tag, " result"}, result, exp_result);
      check({tag, " zero"}, {15'b0, zero}, {15'b0, exp_zero});
      step();
      check({tag, " done pulse"}, {15'b0, done}, 16'd0);
      check({tag, " idle busy"}, {15'b0, busy}, 16'd0);
      check({tag, " idle hold"}, result, exp_result);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      exp_result = '0;
      exp_zero   = 1'b0;
      #2;
      check("rst busy", {15'b0, busy}, 16'd0);
      check("rst done", {15'b0, done}, 16'd0);
      check("rst result", result, 16'h0000);
      check("rst zero", {15'b0, zero}, 16'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post-rst busy", {15'b0, busy}, 16'd0);

      run_op(16'h1111, 16'h1111, "ones");
      run_op(16'h8888, 16'h8888, "min");
      run_op(16'h7777, 16'h7777, "max");
      run_op(16'h1F1F, 16'h0000, "cancel");
      run_op(16'h0000, 16'h0000, "allzero");

      // Back-to-back: start held high through DONE.
      A = 16'h7777;
      B = 16'h1111;
      start = 1'b1;
      step();
      A = 16'h0001;
      B = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         check("b2b first busy", {15'b0, busy}, 16'd1);
         step();
      end
      check("b2b first done", {15'b0, done}, 16'd1);
      check("b2b first result", result, ref_sum(16'h7777, 16'h1111));
      step();
      start = 1'b0;
      check("b2b accepted busy", {15'b0, busy}, 16'd1);
      check("b2b accepted done", {15'b0, done}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("b2b second wait", {15'b0, done}, 16'd0);
      end
      step();
      check("b2b second done", {15'b0, done}, 16'd1);
      check("b2b second result", result, 16'h0001);
      check("b2b second zero", {15'b0, zero}, 16'd0);
      step();
      exp_result = 16'h0001;
      exp_zero   = 1'b0;

      for (int k = 0; k < 20; k++) begin
         run_op(16'($urandom), 16'($urandom), "rand");
      end

      // Abort in the middle of ACCUM; result must be non-zero beforehand.
      run_op(16'h1111, 16'h1111, "pre-abort");
      A = 16'h3333;
      B = 16'h2222;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", {15'b0, busy}, 16'd0);
      check("abort done", {15'b0, done}, 16'd0);
      check("abort result", result, 16'h0000);
      check("abort zero", {15'b0, zero}, 16'd0);
      exp_result = 16'h0000;
      exp_zero   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort no done", {15'b0, done}, 16'd0);
         check("abort no busy", {15'b0, busy}, 16'd0);
      end
      run_op(16'h4321, 16'hC0DE, "after-abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
